// File: rtl/led_round_if.sv
// led_round_if -- handshake bundle between the game FSM and led_round_generator.
//
// Signals:
//   enable_in          game running (level)
//   new_round_in       one-cycle request for an immediate new target
//   hit_in             one-cycle successful-hit marker
//   leds_out           one-hot target, zero when no round is active
//   timer_expired_out  one-cycle miss pulse
//   round_active_out   high while a round is being timed
//   rounds_out         saturating count of rounds started
//
// Modports: master = game side (drives requests), slave = generator.
interface led_round_if #(
  parameter int NUM_LEDS = 18
);
  logic                enable_in;
  logic                new_round_in;
  logic                hit_in;
  logic [NUM_LEDS-1:0] leds_out;
  logic                timer_expired_out;
  logic                round_active_out;
  logic [15:0]         rounds_out;

  modport master (
    output enable_in, new_round_in, hit_in,
    input  leds_out, timer_expired_out, round_active_out, rounds_out
  );

  modport slave (
    input  enable_in, new_round_in, hit_in,
    output leds_out, timer_expired_out, round_active_out, rounds_out
  );
endinterface

// File: rtl/led_round_generator.sv
// led_round_generator -- picks a pseudo-random one-hot LED target for each
// round of the hit-or-miss game, times the round and emits a one-cycle
// expiry pulse on a miss, followed by a dark gap before the next target.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      led_round_if.slave (enable/new_round/hit in; leds, expiry,
//            round_active, rounds out)
//
// Optional feature: define LED_SEQ_SPEEDUP_EN to let each hit shorten the
// round length by STEP_CYCLES down to MIN_CYCLES. Without it the round
// length is fixed at ROUND_CYCLES and hit_in is ignored.
module led_round_generator #(
  parameter int          NUM_LEDS     = 18,
  parameter int          ROUND_CYCLES = 50_000_000,
  parameter int          MIN_CYCLES   = 12_500_000,
  parameter int          STEP_CYCLES  = 2_500_000,
  parameter int          GAP_CYCLES   = 5_000_000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic      clk,
  input  logic      reset_n,
  led_round_if.slave bus
);

  localparam int TW = $clog2(ROUND_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [15:0]         SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [TW-1:0]       LEN_INIT = TW'(ROUND_CYCLES);
  localparam logic [GW-1:0]       GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]          IDX_NONE = 6'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
  localparam logic [3:0]          MAX_TRY  = 4'd8;

  typedef enum logic [1:0] {IDLE, PICK, ACTIVE, GAP} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state, state_nxt;
  logic [15:0]         lfsr;
  logic [NUM_LEDS-1:0] leds, leds_nxt;
  logic                expired, expired_nxt;
  logic                active, active_nxt;
  logic [15:0]         rounds, rounds_nxt;
  logic [5:0]          prev_idx, prev_nxt;
  logic [3:0]          tries, tries_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [GW-1:0]       gap, gap_nxt;
  logic [TW-1:0]       len;

  logic [5:0]          cand;
  logic [5:0]          forced;
  logic [5:0]          pick_idx;
  logic                pick_ok;

`ifdef LED_SEQ_SPEEDUP_EN
  localparam logic [TW-1:0] LEN_MIN  = TW'(MIN_CYCLES);
  localparam logic [TW-1:0] LEN_STEP = TW'(STEP_CYCLES);

  // Shorten by one step but never below the floor; compared one bit wider
  // so neither the sum nor the difference can wrap.
  function automatic logic [TW-1:0] clamp_len(input logic [TW-1:0] v);
    logic [TW:0] lim;
    lim = {1'b0, LEN_MIN} + {1'b0, LEN_STEP};
    return ({1'b0, v} < lim) ? LEN_MIN : (v - LEN_STEP);
  endfunction

  logic [TW-1:0] len_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len <= LEN_INIT;
    end else begin
      len <= len_nxt;
    end
  end
`else
  // Speed-up compiled out: round length is a constant and the speed-up
  // parameters and hit_in are intentionally left without a load.
  localparam int UNUSED_SPEED_CFG = MIN_CYCLES + STEP_CYCLES;
  logic unused_hit;
  assign unused_hit = bus.hit_in;
  assign len = LEN_INIT;
`endif

  always_comb begin
    state_nxt   = state;
    leds_nxt    = leds;
    expired_nxt = 1'b0;
    active_nxt  = 1'b0;
    rounds_nxt  = rounds;
    prev_nxt    = prev_idx;
    tries_nxt   = tries;
    timer_nxt   = timer;
    gap_nxt     = gap;
`ifdef LED_SEQ_SPEEDUP_EN
    len_nxt     = len;
`endif
    pick_ok     = 1'b0;
    pick_idx    = '0;
    cand        = {1'b0, lfsr[4:0]};
    // Fallback index after too many rejected candidates; prev_idx may be
    // NUM_LEDS (nothing picked yet), which wraps to 1 here.
    forced      = prev_idx + 6'd1;
    if (forced >= IDX_NONE) forced = forced - IDX_NONE;

    case (state)
      IDLE: begin
        leds_nxt   = '0;
        rounds_nxt = '0;
        tries_nxt  = '0;
`ifdef LED_SEQ_SPEEDUP_EN
        len_nxt    = LEN_INIT;
`endif
        if (bus.enable_in) state_nxt = PICK;
      end

      PICK: begin
        if (tries == MAX_TRY) begin
          pick_ok  = 1'b1;
          pick_idx = forced;
        end else if ((cand < IDX_NONE) && (cand != prev_idx)) begin
          pick_ok  = 1'b1;
          pick_idx = cand;
        end else begin
          tries_nxt = tries + 4'd1;
        end
        if (pick_ok) begin
          leds_nxt   = LED_ONE << pick_idx;
          prev_nxt   = pick_idx;
          timer_nxt  = len - TW'(1);
          rounds_nxt = sat_inc16(rounds);
          active_nxt = 1'b1;
          tries_nxt  = '0;
          state_nxt  = ACTIVE;
        end
      end

      ACTIVE: begin
        active_nxt = 1'b1;
        timer_nxt  = timer - TW'(1);
`ifdef LED_SEQ_SPEEDUP_EN
        // Only len changes here; the running timer keeps the current round.
        if (bus.hit_in) len_nxt = clamp_len(len);
`endif
        if (bus.new_round_in) begin
          leds_nxt   = '0;
          active_nxt = 1'b0;
          tries_nxt  = '0;
          state_nxt  = PICK;
        end else if (timer == '0) begin
          expired_nxt = 1'b1;
          leds_nxt    = '0;
          active_nxt  = 1'b0;
          gap_nxt     = GAP_LOAD;
          state_nxt   = GAP;
        end
      end

      GAP: begin
        leds_nxt = '0;
        gap_nxt  = gap - GW'(1);
        if (gap == '0) begin
          tries_nxt = '0;
          state_nxt = PICK;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Disable wins over everything, including a same-cycle expiry. The
    // round count and length are cleared on the way in so they read zero
    // / initial in the first IDLE cycle.
    if (!bus.enable_in && (state != IDLE)) begin
      state_nxt   = IDLE;
      leds_nxt    = '0;
      expired_nxt = 1'b0;
      active_nxt  = 1'b0;
      rounds_nxt  = '0;
`ifdef LED_SEQ_SPEEDUP_EN
      len_nxt     = LEN_INIT;
`endif
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lfsr     <= SEED;
      leds     <= '0;
      expired  <= 1'b0;
      active   <= 1'b0;
      rounds   <= '0;
      prev_idx <= IDX_NONE;
      tries    <= '0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_step(lfsr);
      leds     <= leds_nxt;
      expired  <= expired_nxt;
      active   <= active_nxt;
      rounds   <= rounds_nxt;
      prev_idx <= prev_nxt;
      tries    <= tries_nxt;
    end
  end

  // Counters are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    timer <= timer_nxt;
    gap   <= gap_nxt;
  end

  assign bus.leds_out          = leds;
  assign bus.timer_expired_out = expired;
  assign bus.round_active_out  = active;
  assign bus.rounds_out        = rounds;

endmodule

// File: tb/tb_led_round_generator.sv
// tb_led_round_generator -- directed bench for led_round_generator with
// NUM_LEDS=18, ROUND_CYCLES=20, MIN_CYCLES=8, STEP_CYCLES=4, GAP_CYCLES=3.
// Expected round lengths are queued when a round is started and popped
// when the round ends. Compile with LED_SEQ_SPEEDUP_EN to match a DUT
// built with the speed-up feature.
module tb_led_round_generator;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   exp_q[$];
  int   pulse_cnt;
  int   bad_onehot;

`ifdef LED_SEQ_SPEEDUP_EN
  int len_tab[5] = '{20, 16, 12, 8, 8};
`else
  int len_tab[5] = '{20, 20, 20, 20, 20};
`endif
  int hit_tab[5] = '{1, 1, 11, 1, -1};

  led_round_if #(.NUM_LEDS(18)) bus ();

  led_round_generator #(
    .NUM_LEDS(18), .ROUND_CYCLES(20), .MIN_CYCLES(8),
    .STEP_CYCLES(4), .GAP_CYCLES(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit onehot(input logic [17:0] v);
    return (v != 18'd0) && ((v & (v - 18'd1)) == 18'd0);
  endfunction

  // Mid-cycle monitors: expiry pulses, and leds consistent with round_active.
  always @(negedge clk) begin
    if (bus.timer_expired_out === 1'b1) pulse_cnt++;
    if (bus.round_active_out === 1'b1) begin
      if (!onehot(bus.leds_out)) bad_onehot++;
    end else if (bus.leds_out !== 18'd0) begin
      bad_onehot++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_led(input int bound, output int lat);
    lat = 0;
    while (bus.leds_out == 18'd0 && lat < bound) begin
      tick();
      lat++;
    end
  endtask

  task automatic measure(input int hit_at, output int n);
    n = 0;
    while (bus.round_active_out === 1'b1 && n < 100) begin
      bus.hit_in = (n == hit_at);
      tick();
      n++;
    end
    bus.hit_in = 1'b0;
  endtask

  task automatic wait_dark(output int d);
    d = 0;
    while (bus.leds_out == 18'd0 && d < 40) begin
      d++;
      tick();
    end
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, n, d, p0, idle_viol, started, lat_bad, distinct_bad;
    logic [17:0] prev_led;
    int exp_cur;

    checks = 0; errors = 0; pulse_cnt = 0; bad_onehot = 0;
    bus.enable_in = 1'b0; bus.new_round_in = 1'b0; bus.hit_in = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_leds", bus.leds_out, 0);
    check("rst_expired", bus.timer_expired_out, 0);
    check("rst_active", bus.round_active_out, 0);
    check("rst_rounds", bus.rounds_out, 0);
    #3 reset_n = 1'b1;

    // Held in IDLE with enable low
    idle_viol = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.leds_out != 0 || bus.timer_expired_out || bus.round_active_out ||
          bus.rounds_out != 0) idle_viol++;
    end
    check("idle_hold", idle_viol, 0);

    // First natural round
    exp_q.push_back(20);
    bus.enable_in = 1'b1;
    wait_led(12, lat);
    check("first_led_lat", (lat >= 2 && lat <= 10), 1);
    check("first_onehot", onehot(bus.leds_out), 1);
    check("first_active", bus.round_active_out, 1);
    check("first_rounds", bus.rounds_out, 1);
    prev_led = bus.leds_out;
    measure(-1, n);
    check("round1_len", n, exp_q.pop_front());
    check("expiry_pulse", bus.timer_expired_out, 1);
    check("gap_leds", bus.leds_out, 0);
    p0 = pulse_cnt;
    wait_dark(d);
    check("dark_len", (d >= 4 && d <= 12), 1);
    check("single_pulse", pulse_cnt - p0, 1);
    check("second_distinct", (bus.leds_out != prev_led) && onehot(bus.leds_out), 1);
    check("second_rounds", bus.rounds_out, 2);

    // new_round on 5th ACTIVE cycle
    p0 = pulse_cnt;
    repeat (4) tick();
    bus.new_round_in = 1'b1;
    tick();
    bus.new_round_in = 1'b0;
    check("nr_leds_off", bus.leds_out, 0);
    check("nr_active_off", bus.round_active_out, 0);
    wait_led(12, lat);
    check("nr_relight_lat", (lat >= 1 && lat <= 9), 1);
    check("nr_no_pulse", pulse_cnt - p0, 0);
    exp_q.push_back(20);
    measure(-1, n);
    check("nr_full_round", n, exp_q.pop_front());
    wait_dark(d);

    // Hit sequence: one hit in each of the first four rounds
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back(len_tab[r]);
      measure(hit_tab[r], n);
      check("hit_round_len", n, exp_q.pop_front());
      wait_dark(d);
    end
    exp_cur = len_tab[4];

    // new_round on the terminal ACTIVE cycle
    p0 = pulse_cnt;
    repeat (exp_cur - 1) tick();
    check("term_active", bus.round_active_out, 1);
    bus.new_round_in = 1'b1;
    tick();
    bus.new_round_in = 1'b0;
    check("term_no_expiry", bus.timer_expired_out, 0);
    check("term_leds_off", bus.leds_out, 0);
    wait_led(12, lat);
    check("term_pick_lat", (lat >= 1 && lat <= 9), 1);
    check("term_pulse_cnt", pulse_cnt - p0, 0);
    exp_q.push_back(exp_cur);
    measure(-1, n);
    check("term_next_len", n, exp_q.pop_front());

    // new_round during GAP is ignored
    bus.new_round_in = 1'b1;
    tick();
    bus.new_round_in = 1'b0;
    d = 1;
    while (bus.leds_out == 18'd0 && d < 40) begin
      d++;
      tick();
    end
    check("gap_nr_ignored", (d >= 4 && d <= 12), 1);

    // Disable mid-ACTIVE
    repeat (3) tick();
    bus.enable_in = 1'b0;
    tick();
    check("dis_leds", bus.leds_out, 0);
    check("dis_active", bus.round_active_out, 0);
    check("dis_rounds", bus.rounds_out, 0);
    repeat (5) tick();
    check("dis_hold", {bus.leds_out, bus.round_active_out, bus.timer_expired_out}, 0);
    exp_q.push_back(20);
    bus.enable_in = 1'b1;
    wait_led(12, lat);
    check("reen_lat", (lat >= 2 && lat <= 10), 1);
    check("reen_rounds", bus.rounds_out, 1);
    measure(-1, n);
    check("reen_len", n, exp_q.pop_front());
    wait_dark(d);

    // Asynchronous reset mid-ACTIVE
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst", {bus.leds_out, bus.round_active_out, bus.timer_expired_out,
                        bus.rounds_out}, 0);
    #2 reset_n = 1'b1;

    // 1000 rounds
    started = 0; lat_bad = 0; distinct_bad = 0; prev_led = '0;
    for (int i = 0; i < 1000; i++) begin
      wait_led(20, lat);
      if (bus.leds_out == 18'd0) lat_bad++;
      started++;
      if (i != 0 && bus.leds_out == prev_led) distinct_bad++;
      prev_led = bus.leds_out;
      if (i % 50 == 49) begin
        measure(-1, n);
      end else begin
        tick();
        tick();
        bus.new_round_in = 1'b1;
        tick();
        bus.new_round_in = 1'b0;
      end
    end
    check("many_timeouts", lat_bad, 0);
    check("many_distinct", distinct_bad, 0);
    check("many_rounds", bus.rounds_out, started);
    check("onehot_monitor", bad_onehot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
